// File: rtl/ahb_lite_input_stage_err_if.sv
// Master-side AHB-lite bus of one interconnect input stage.
// The master drives the address phase and the stage returns the data-phase response.
interface ahb_lite_input_stage_err_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              ma_HREADY;
    logic              ma_HSEL;
    logic              ma_HWRITE;
    logic              ma_HMASTLOCK;
    logic [1:0]        ma_HTRANS;
    logic [2:0]        ma_HBURST;
    logic [2:0]        ma_HSIZE;
    logic [3:0]        ma_HPROT;
    logic [W_ADDR-1:0] ma_HADDR;
    logic [W_DATA-1:0] ma_HWDATA;
    logic              out_ma_HREADY;
    logic [1:0]        out_ma_HRESP;
    logic [W_DATA-1:0] out_ma_HRDATA;

    modport master (
        output ma_HREADY, ma_HSEL, ma_HWRITE, ma_HMASTLOCK, ma_HTRANS, ma_HBURST,
               ma_HSIZE, ma_HPROT, ma_HADDR, ma_HWDATA,
        input  out_ma_HREADY, out_ma_HRESP, out_ma_HRDATA
    );

    modport slave (
        input  ma_HREADY, ma_HSEL, ma_HWRITE, ma_HMASTLOCK, ma_HTRANS, ma_HBURST,
               ma_HSIZE, ma_HPROT, ma_HADDR, ma_HWDATA,
        output out_ma_HREADY, out_ma_HRESP, out_ma_HRDATA
    );
endinterface

// File: rtl/ahb_lite_input_stage_err.sv
// AHB-lite interconnect input stage: decode, hold-until-granted, and a two-cycle ERROR for unmapped accesses.
// Define AHB_IS_TIMEOUT_EN to abort a starved held transfer with ERROR after WAIT_TIMEOUT cycles.
module ahb_lite_input_stage_err #(
    parameter int                          N_SLAVE      = 4,
    parameter int                          W_SLAVE      = 2,
    parameter int                          W_ADDR       = 32,
    parameter int                          W_DATA       = 32,
    parameter logic [N_SLAVE*W_ADDR-1:0]   SLV_BASE     = {N_SLAVE{{W_ADDR{1'b0}}}},
    parameter logic [N_SLAVE*W_ADDR-1:0]   SLV_MASK     = {N_SLAVE{32'hF000_0000}},
    parameter int                          WAIT_TIMEOUT = 16,
    parameter int                          W_TMO        = 8
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    ahb_lite_input_stage_err_if.slave   mif,
    input  logic [N_SLAVE-1:0]          sl_active,
    input  logic [N_SLAVE-1:0]          sl_HREADY,
    input  logic [2*N_SLAVE-1:0]        sl_HRESP,
    input  logic [W_DATA*N_SLAVE-1:0]   sl_HRDATA,
    output logic [1:0]                  out_sl_HTRANS,
    output logic [2:0]                  out_sl_HBURST,
    output logic [2:0]                  out_sl_HSIZE,
    output logic [3:0]                  out_sl_HPROT,
    output logic                        out_sl_HMASTLOCK,
    output logic [W_ADDR-1:0]           out_sl_HADDR,
    output logic                        out_sl_HWRITE,
    output logic [W_DATA-1:0]           out_sl_HWDATA,
    output logic [N_SLAVE-1:0]          out_sl_HSEL,
    output logic                        out_held_trans,
    output logic [2:0]                  q_state
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_XFER = 3'd1,
        ST_WAIT = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    if ((WAIT_TIMEOUT < 1) || (WAIT_TIMEOUT > (2 ** W_TMO) - 1)) begin : g_bad_timeout
        $fatal(1, "WAIT_TIMEOUT does not fit the W_TMO counter");
    end

    state_t              state_r, nxt_state_s;
    logic [W_SLAVE-1:0]  q_slave_r, dec_idx_s;
    logic [N_SLAVE-1:0]  match_s;
    logic                mapped_s, req_s, accept_s, pass_s, cap_en_s, tmo_hit_s;
    logic [1:0]          cap_htrans_r;
    logic [2:0]          cap_hburst_r, cap_hsize_r;
    logic [3:0]          cap_hprot_r;
    logic [W_ADDR-1:0]   cap_haddr_r;
    logic                cap_hwrite_r, cap_hlock_r;

    assign req_s         = mif.ma_HSEL & mif.ma_HTRANS[1];
    assign out_sl_HWDATA = mif.ma_HWDATA;
    assign q_state       = state_r;
    assign mif.out_ma_HRDATA = sl_HRDATA[int'(q_slave_r) * W_DATA +: W_DATA];

    // Forwarded address phase: captured copy while held, live master bus otherwise.
    always_comb begin
        out_sl_HTRANS    = mif.ma_HTRANS;
        out_sl_HBURST    = mif.ma_HBURST;
        out_sl_HSIZE     = mif.ma_HSIZE;
        out_sl_HPROT     = mif.ma_HPROT;
        out_sl_HMASTLOCK = mif.ma_HMASTLOCK;
        out_sl_HADDR     = mif.ma_HADDR;
        out_sl_HWRITE    = mif.ma_HWRITE;
        case (state_r)
            ST_WAIT: begin
                out_sl_HTRANS    = cap_htrans_r;
                out_sl_HBURST    = cap_hburst_r;
                out_sl_HSIZE     = cap_hsize_r;
                out_sl_HPROT     = cap_hprot_r;
                out_sl_HMASTLOCK = cap_hlock_r;
                out_sl_HADDR     = cap_haddr_r;
                out_sl_HWRITE    = cap_hwrite_r;
            end
            ST_ERR1: out_sl_HTRANS = HTRANS_IDLE;
            default: out_sl_HTRANS = mif.ma_HTRANS;
        endcase
    end

    for (genvar i = 0; i < N_SLAVE; i++) begin : g_match
        assign match_s[i] = (out_sl_HADDR & SLV_MASK[i*W_ADDR +: W_ADDR]) == SLV_BASE[i*W_ADDR +: W_ADDR];
    end

    // Lowest matching slave index wins; the one-hot select isolates the lowest set match bit.
    always_comb begin
        dec_idx_s = '0;
        for (int i = N_SLAVE - 1; i >= 0; i--) begin
            dec_idx_s = match_s[i] ? W_SLAVE'(i) : dec_idx_s;
        end
    end

    assign mapped_s    = |match_s;
    assign out_sl_HSEL = match_s & (~match_s + N_SLAVE'(1'b1));

`ifdef AHB_IS_TIMEOUT_EN
    logic [W_TMO-1:0] tmo_cnt_r;

    assign tmo_hit_s = (tmo_cnt_r == W_TMO'(WAIT_TIMEOUT - 1));

    // Counts consecutive starved cycles in WAIT; any exit clears it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && (nxt_state_s == ST_WAIT)) begin
            tmo_cnt_r <= tmo_cnt_r + W_TMO'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next state and master-side response; acceptance is evaluated in IDLE, ERR2 and XFER.
    always_comb begin
        nxt_state_s       = state_r;
        accept_s          = 1'b0;
        pass_s            = 1'b0;
        cap_en_s          = 1'b0;
        out_held_trans    = 1'b0;
        mif.out_ma_HREADY = 1'b1;
        mif.out_ma_HRESP  = HRESP_OKAY;
        case (state_r)
            ST_IDLE: begin
                pass_s         = 1'b1;
                accept_s       = req_s & mif.ma_HREADY;
                out_held_trans = req_s & mapped_s;
            end
            ST_ERR2: begin
                mif.out_ma_HRESP = HRESP_ERROR;
                pass_s           = 1'b1;
                accept_s         = req_s & mif.ma_HREADY;
                out_held_trans   = req_s & mapped_s;
            end
            ST_XFER: begin
                mif.out_ma_HREADY = sl_HREADY[q_slave_r];
                mif.out_ma_HRESP  = sl_HRESP[2*int'(q_slave_r) +: 2];
                pass_s            = sl_HREADY[q_slave_r];
                accept_s          = req_s & sl_HREADY[q_slave_r];
                out_held_trans    = req_s & mapped_s;
            end
            ST_WAIT: begin
                mif.out_ma_HREADY = 1'b0;
                out_held_trans    = 1'b1;
                if (sl_active[q_slave_r] && sl_HREADY[q_slave_r]) begin
                    nxt_state_s = ST_XFER;
                end else if (tmo_hit_s) begin
                    nxt_state_s = ST_ERR1;
                end else begin
                    nxt_state_s = ST_WAIT;
                end
            end
            ST_ERR1: begin
                mif.out_ma_HREADY = 1'b0;
                mif.out_ma_HRESP  = HRESP_ERROR;
                nxt_state_s       = ST_ERR2;
            end
            default: nxt_state_s = ST_IDLE;
        endcase

        if (pass_s) begin
            if (!accept_s) begin
                nxt_state_s = ST_IDLE;
            end else if (!mapped_s) begin
                nxt_state_s = ST_ERR1;
            end else if (sl_active[dec_idx_s]) begin
                nxt_state_s = ST_XFER;
            end else begin
                nxt_state_s = ST_WAIT;
                cap_en_s    = 1'b1;
            end
        end else begin
            cap_en_s = 1'b0;
        end
    end

    // State, target slave and captured address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r      <= ST_IDLE;
            q_slave_r    <= '0;
            cap_htrans_r <= HTRANS_IDLE;
            cap_hburst_r <= 3'b000;
            cap_hsize_r  <= 3'b010;
            cap_hprot_r  <= 4'b0011;
            cap_haddr_r  <= '0;
            cap_hwrite_r <= 1'b0;
            cap_hlock_r  <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            if (pass_s && accept_s) begin
                q_slave_r <= dec_idx_s;
            end
            if (cap_en_s) begin
                cap_htrans_r <= mif.ma_HTRANS;
                cap_hburst_r <= mif.ma_HBURST;
                cap_hsize_r  <= mif.ma_HSIZE;
                cap_hprot_r  <= mif.ma_HPROT;
                cap_haddr_r  <= mif.ma_HADDR;
                cap_hwrite_r <= mif.ma_HWRITE;
                cap_hlock_r  <= mif.ma_HMASTLOCK;
            end
        end
    end
endmodule

// File: tb/tb_ahb_lite_input_stage_err.sv
// Directed self-checking bench for ahb_lite_input_stage_err (four slaves, WAIT_TIMEOUT=4).
module tb_ahb_lite_input_stage_err;
    localparam int N_SLAVE = 4;
    localparam int W_ADDR  = 32;
    localparam int W_DATA  = 32;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic [N_SLAVE-1:0]        sl_active;
    logic [N_SLAVE-1:0]        sl_HREADY;
    logic [2*N_SLAVE-1:0]      sl_HRESP;
    logic [W_DATA*N_SLAVE-1:0] sl_HRDATA;
    logic [1:0]  out_sl_HTRANS;
    logic [2:0]  out_sl_HBURST, out_sl_HSIZE, q_state;
    logic [3:0]  out_sl_HPROT;
    logic        out_sl_HMASTLOCK, out_sl_HWRITE, out_held_trans;
    logic [W_ADDR-1:0]  out_sl_HADDR;
    logic [W_DATA-1:0]  out_sl_HWDATA;
    logic [N_SLAVE-1:0] out_sl_HSEL;

    int checks   = 0;
    int failures = 0;

    ahb_lite_input_stage_err_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) mif ();

    ahb_lite_input_stage_err #(
        .N_SLAVE(N_SLAVE), .W_SLAVE(2), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
        .SLV_BASE({32'h3000_0000, 32'h2000_0000, 32'h8000_0000, 32'h0000_0000}),
        .SLV_MASK({4{32'hF000_0000}}),
        .WAIT_TIMEOUT(4), .W_TMO(8)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .mif(mif),
        .sl_active(sl_active), .sl_HREADY(sl_HREADY), .sl_HRESP(sl_HRESP), .sl_HRDATA(sl_HRDATA),
        .out_sl_HTRANS(out_sl_HTRANS), .out_sl_HBURST(out_sl_HBURST), .out_sl_HSIZE(out_sl_HSIZE),
        .out_sl_HPROT(out_sl_HPROT), .out_sl_HMASTLOCK(out_sl_HMASTLOCK), .out_sl_HADDR(out_sl_HADDR),
        .out_sl_HWRITE(out_sl_HWRITE), .out_sl_HWDATA(out_sl_HWDATA), .out_sl_HSEL(out_sl_HSEL),
        .out_held_trans(out_held_trans), .q_state(q_state)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr);
        mif.ma_HSEL   = sel;
        mif.ma_HTRANS = trans;
        mif.ma_HADDR  = addr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.ma_HREADY = 1'b1; mif.ma_HWRITE = 1'b0; mif.ma_HMASTLOCK = 1'b0;
        mif.ma_HBURST = 3'b000; mif.ma_HSIZE = 3'b010; mif.ma_HPROT = 4'b0011;
        mif.ma_HWDATA = 32'h0000_CAFE;
        drive(1'b0, 2'b00, 32'h1234_5678);
        sl_active = 4'b0000; sl_HREADY = 4'b1111; sl_HRESP = 8'h00;
        sl_HRDATA = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

        // Reset state
        #3;
        chk("rst_state", 64'(q_state), 64'd0);
        chk("rst_hready", 64'(mif.out_ma_HREADY), 64'd1);
        chk("rst_hresp", 64'(mif.out_ma_HRESP), 64'd0);
        chk("rst_held", 64'(out_held_trans), 64'd0);
        chk("rst_haddr", 64'(out_sl_HADDR), 64'h1234_5678);
        chk("rst_hrdata", 64'(mif.out_ma_HRDATA), 64'hAAAA_0000);
        chk("rst_hwdata", 64'(out_sl_HWDATA), 64'h0000_CAFE);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK) HRESETn = 1'b1;

        // Granted NONSEQ to slave 0: zero-cycle forwarding
        step();
        mif.ma_HWRITE = 1'b1; sl_active = 4'b0001;
        drive(1'b1, 2'b10, 32'h0000_0010);
        #3;
        chk("fwd_hsel", 64'(out_sl_HSEL), 64'h1);
        chk("fwd_held", 64'(out_held_trans), 64'd1);
        chk("fwd_hready", 64'(mif.out_ma_HREADY), 64'd1);
        chk("fwd_hwrite", 64'(out_sl_HWRITE), 64'd1);
        step();
        drive(1'b0, 2'b00, 32'h0000_0010); mif.ma_HWRITE = 1'b0;
        #3;
        chk("fwd_xfer", 64'(q_state), 64'd1);
        chk("fwd_hrdata", 64'(mif.out_ma_HRDATA), 64'hAAAA_0000);
        step();
        #3;
        chk("fwd_idle", 64'(q_state), 64'd0);

        // Slave 1 not granted for three cycles
        sl_active = 4'b0000;
        drive(1'b1, 2'b10, 32'h8000_0000);
        #3;
        chk("wt_hsel", 64'(out_sl_HSEL), 64'h2);
        chk("wt_held0", 64'(out_held_trans), 64'd1);
        step();
        drive(1'b0, 2'b00, 32'h0000_0100);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) sl_active = 4'b0010;
            #3;
            chk("wt_state", 64'(q_state), 64'd2);
            chk("wt_hready", 64'(mif.out_ma_HREADY), 64'd0);
            chk("wt_haddr", 64'(out_sl_HADDR), 64'h8000_0000);
            chk("wt_htrans", 64'(out_sl_HTRANS), 64'd2);
            chk("wt_held", 64'(out_held_trans), 64'd1);
            step();
        end
        #3;
        chk("wt_xfer", 64'(q_state), 64'd1);
        chk("wt_hrdata", 64'(mif.out_ma_HRDATA), 64'hBBBB_0001);
        chk("wt_live_addr", 64'(out_sl_HADDR), 64'h0000_0100);
        step();
        sl_active = 4'b0000;
        #3;
        chk("wt_idle", 64'(q_state), 64'd0);

        // Unmapped address: two-cycle ERROR
        drive(1'b1, 2'b10, 32'h5000_0000);
        #3;
        chk("err_hsel", 64'(out_sl_HSEL), 64'h0);
        chk("err_held0", 64'(out_held_trans), 64'd0);
        step();
        #3;
        chk("err1_state", 64'(q_state), 64'd3);
        chk("err1_hready", 64'(mif.out_ma_HREADY), 64'd0);
        chk("err1_hresp", 64'(mif.out_ma_HRESP), 64'd1);
        chk("err1_htrans", 64'(out_sl_HTRANS), 64'd0);
        chk("err1_held", 64'(out_held_trans), 64'd0);
        step();
        drive(1'b0, 2'b00, 32'h5000_0000);
        #3;
        chk("err2_state", 64'(q_state), 64'd4);
        chk("err2_hready", 64'(mif.out_ma_HREADY), 64'd1);
        chk("err2_hresp", 64'(mif.out_ma_HRESP), 64'd1);
        step();
        #3;
        chk("err_idle", 64'(q_state), 64'd0);
        chk("err_idle_hresp", 64'(mif.out_ma_HRESP), 64'd0);

        // Starved transfer to slave 2
        drive(1'b1, 2'b10, 32'h2000_0000);
        step();
        drive(1'b0, 2'b00, 32'h0000_0000);
`ifdef AHB_IS_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("tmo_wait", 64'(q_state), 64'd2);
            step();
        end
        #3;
        chk("tmo_err1", 64'(q_state), 64'd3);
        chk("tmo_err1_hready", 64'(mif.out_ma_HREADY), 64'd0);
        chk("tmo_err1_hresp", 64'(mif.out_ma_HRESP), 64'd1);
        chk("tmo_err1_held", 64'(out_held_trans), 64'd0);
        step();
        #3;
        chk("tmo_err2", 64'(q_state), 64'd4);
        chk("tmo_err2_hready", 64'(mif.out_ma_HREADY), 64'd1);
        step();
        #3;
        chk("tmo_idle", 64'(q_state), 64'd0);
        chk("tmo_idle_held", 64'(out_held_trans), 64'd0);
`else
        for (int k = 0; k < 8; k++) begin
            #3;
            chk("notmo_wait", 64'(q_state), 64'd2);
            step();
        end
        sl_active = 4'b0100;
        #3;
        chk("notmo_wait_last", 64'(q_state), 64'd2);
        step();
        #3;
        chk("notmo_xfer", 64'(q_state), 64'd1);
        chk("notmo_hrdata", 64'(mif.out_ma_HRDATA), 64'hCCCC_0002);
        step();
        sl_active = 4'b0000;
        #3;
        chk("notmo_idle", 64'(q_state), 64'd0);
`endif

        // Reset asserted mid-WAIT
        drive(1'b1, 2'b10, 32'h3000_0000);
        #3;
        chk("rw_hsel", 64'(out_sl_HSEL), 64'h8);
        step();
        drive(1'b0, 2'b00, 32'h0000_0000);
        #3;
        chk("rw_wait", 64'(q_state), 64'd2);
        #1 HRESETn = 1'b0;
        #1;
        chk("rw_state", 64'(q_state), 64'd0);
        chk("rw_hready", 64'(mif.out_ma_HREADY), 64'd1);
        chk("rw_held", 64'(out_held_trans), 64'd0);
        @(negedge HCLK) HRESETn = 1'b1;
        sl_active = 4'b1000;
        step();
        #3;
        chk("rw_discard", 64'(q_state), 64'd0);
        chk("rw_hrdata", 64'(mif.out_ma_HRDATA), 64'hAAAA_0000);

        // SEQ burst into slave 0 with one slave wait state
        sl_active = 4'b0001;
        drive(1'b1, 2'b10, 32'h0000_0000);
        #3;
        chk("bst_held", 64'(out_held_trans), 64'd1);
        step();
        drive(1'b1, 2'b11, 32'h0000_0004);
        sl_HREADY = 4'b1110;
        #3;
        chk("bst_stall_state", 64'(q_state), 64'd1);
        chk("bst_stall_hready", 64'(mif.out_ma_HREADY), 64'd0);
        chk("bst_stall_haddr", 64'(out_sl_HADDR), 64'h0000_0004);
        chk("bst_stall_htrans", 64'(out_sl_HTRANS), 64'd3);
        step();
        sl_HREADY = 4'b1111;
        #3;
        chk("bst_go_state", 64'(q_state), 64'd1);
        chk("bst_go_hready", 64'(mif.out_ma_HREADY), 64'd1);
        step();
        drive(1'b1, 2'b11, 32'h0000_0008);
        sl_HRESP = 8'b0000_0001;
        #3;
        chk("bst_beat2_state", 64'(q_state), 64'd1);
        chk("bst_resp_pass", 64'(mif.out_ma_HRESP), 64'd1);
        chk("bst_beat2_haddr", 64'(out_sl_HADDR), 64'h0000_0008);
        step();
        sl_HRESP = 8'h00;
        drive(1'b0, 2'b00, 32'h0000_0008);
        #3;
        chk("bst_last_state", 64'(q_state), 64'd1);
        step();
        #3;
        chk("bst_idle", 64'(q_state), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_lite_input_stage_err.md
# ahb_lite_input_stage_err

Parametrised AHB-lite interconnect input stage, one per master port, sitting between a master and the per-slave output stages. It decodes the master address against per-slave base/mask maps and forwards or holds the address phase until the target output stage grants it. It returns the slave data phase to the master. It adds a protocol-correct two-cycle ERROR response for unmapped addresses and a wait-timeout that aborts a starved held transfer with ERROR.

## Interface
Parameters:
- N_SLAVE, 4: number of slave output stages.
- W_SLAVE, 2: ceil(log2(N_SLAVE)).
- W_ADDR, 32: address width.
- W_DATA, 32: data width.
- SLV_BASE, {N_SLAVE{W_ADDR'h0}}: packed per-slave base addresses; slave i occupies bits [i*W_ADDR +: W_ADDR].
- SLV_MASK, {N_SLAVE{32'hF0000000}}: packed per-slave compare masks.
- WAIT_TIMEOUT, 16: maximum cycles in WAIT before abort. Range 1..2^W_TMO-1.
- W_TMO, 8: timeout counter width.

Ports (all signals use one clock; reset is asynchronous and active-low):
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- ma_HREADY, ma_HSEL, ma_HWRITE, ma_HMASTLOCK  in  1 each  master bus-level ready, select, write, lock.
- ma_HTRANS/HBURST/HSIZE/HPROT  in  2/3/3/4  master address-phase controls.
- ma_HADDR  in  W_ADDR;  ma_HWDATA  in  W_DATA.
- sl_active  in  N_SLAVE  output stage i has granted this master.
- sl_HREADY  in  N_SLAVE;  sl_HRESP  in  2*N_SLAVE;  sl_HRDATA  in  W_DATA*N_SLAVE.
- out_ma_HREADY  out  1;  out_ma_HRESP  out  2;  out_ma_HRDATA  out  W_DATA.
- out_sl_HTRANS/HBURST/HSIZE/HPROT/HMASTLOCK/HADDR/HWRITE  out  forwarded address phase.
- out_sl_HWDATA  out  W_DATA  equals ma_HWDATA.
- out_sl_HSEL  out  N_SLAVE  one-hot decode of out_sl_HADDR; all zero if unmapped.
- out_held_trans  out  1  a valid request is pending toward out_sl_HSEL.
- q_state  out  3  debug state.

## Operation
- Decode: slave i matches when (out_sl_HADDR & MASK_i) == BASE_i. The lowest index wins. No match means unmapped.
- A valid request is ma_HSEL with HTRANS = NONSEQ or SEQ. A request is accepted in IDLE/ERR2 when ma_HREADY=1, and in XFER when sl_HREADY[q_slave]=1.
- States: IDLE=0, XFER=1, WAIT=2, ERR1=3, ERR2=4.
- IDLE: out_ma_HREADY=1, HRESP=OKAY, out_sl_* = ma_*.
  - Accepted request, unmapped → ERR1, held=0.
  - Accepted request, mapped and granted → XFER.
  - Accepted request, mapped and not granted → capture address phase, go to WAIT.
- XFER: out_ma_HREADY/HRESP = selected q_slave data phase; out_sl_* = ma_*.
  - On sl_HREADY=1: accepted request follows the same three IDLE branches.
  - On sl_HREADY=1 with no request → IDLE.
  - An ERROR from the slave passes through unchanged.
- WAIT: out_ma_HREADY=0, HRESP=OKAY, out_sl_* = captured registers, held=1, timeout counter increments.
  - Granted with sl_HREADY[q_slave]=1 → XFER, counter cleared.
- ERR1: out_ma_HREADY=0, HRESP=ERROR, out_sl_HTRANS=IDLE, held=0 → ERR2.
- ERR2: out_ma_HREADY=1, HRESP=ERROR, out_sl_* = ma_*. Request acceptance as in IDLE; otherwise → IDLE.
- out_ma_HRDATA = sl_HRDATA of q_slave in every state.
- q_slave updates to the decoded slave on every acceptance.

## Timing
- Reset values:
  - State IDLE, q_slave 0, counter 0.
  - Captured registers: HTRANS IDLE, HSIZE word, HBURST SINGLE, HPROT 4'b0011, HADDR 0, HWRITE 0, HMASTLOCK 0.
  - Outputs after reset: out_ma_HREADY=1, out_ma_HRESP=OKAY, out_held_trans=0, out_sl_* = ma_*.
- Zero-cycle forwarding when the target is granted. Each cycle spent in WAIT adds one master wait state.
- The ERROR response is always exactly 2 cycles: one with HREADY=0, then one with HREADY=1.
- Reset asserted mid-WAIT or mid-ERR returns immediately to IDLE. The captured transfer is discarded.
- Grant and timeout in the same cycle: grant wins.

## Configuration
- AHB_IS_TIMEOUT_EN defined:
  - In WAIT, when the counter reaches WAIT_TIMEOUT-1 without a grant → ERR1.
  - out_held_trans drops in ERR1 and the captured request is dropped.
- AHB_IS_TIMEOUT_EN undefined: no counter is built, and WAIT persists until granted.

## Test plan
- Reset mid-WAIT: assert HRESETn=0 → out_ma_HREADY=1, q_state=0 asynchronously.
- IDLE, NONSEQ write to 0x0000_0010 (slave 0), sl_active=0001 → same cycle: out_sl_HSEL=0001, held=1, HREADY=1; next cycle: XFER.
- NONSEQ to 0x8000_0000, sl_active[1]=0 for 3 cycles, then granted → 3 master wait cycles with out_sl_HADDR=0x8000_0000 held, then XFER.
- Unmapped 0x5000_0000 → following cycles: HREADY/HRESP = 0/ERROR, then 1/ERROR, then IDLE; out_sl_HTRANS=IDLE during ERR1.
- With AHB_IS_TIMEOUT_EN and WAIT_TIMEOUT=4, target never granted → 4 WAIT cycles, then ERR1, ERR2, IDLE, held=0.
- Back-to-back SEQ burst into slave 0 while slave 0 inserts one HREADY=0 cycle → out_ma_HREADY mirrors it; address is not re-captured and remains XFER.
